// File: rtl/nibble_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// nibble_ctrl_pkg : shared widths and FSM state type for nibble_load_ctrl
// Rev 1.0
// ============================================================================
package nibble_ctrl_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_HIGH = 2'd0,
    ST_LOW  = 2'd1,
    ST_HOLD = 2'd2
  } nib_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_load_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_load_ctrl : nibble handshake to EN_HIGH/EN_LOW byte-assembly strobes
// Rev 1.0
// ============================================================================
module nibble_load_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NIB_W-1:0] NIB_IN,
  input  logic             NIB_VALID,
  output logic             NIB_READY,
  output logic [NIB_W-1:0] NIB_OUT,
  output logic             EN_HIGH,
  output logic             EN_LOW,
  output logic             BYTE_VALID,
  input  logic             BYTE_ACK,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] BYTE_COUNT
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  nib_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q,   err_d;
  logic             xfer;

  // Handshake is gated by RESET so no strobe can reach the data path during reset.
  assign NIB_READY   = !RESET && (state_q != ST_HOLD);
  assign xfer        = NIB_VALID && NIB_READY;
  assign NIB_OUT     = NIB_IN;
  assign EN_HIGH     = xfer && (state_q == ST_HIGH);
  assign EN_LOW      = xfer && (state_q == ST_LOW);
  assign BYTE_VALID  = (state_q == ST_HOLD);
  assign TIMEOUT_ERR = err_q;
  assign BYTE_COUNT  = count_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      ST_HIGH: begin
        if (xfer) begin
          state_d = ST_LOW;
          timer_d = '0;
        end
      end
      ST_LOW: begin
        // A low nibble arriving on the expiry cycle wins over the timeout.
        if (xfer) begin
          state_d = ST_HOLD;
          count_d = count_q + 1'b1;
        end else begin
          if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
          if (timer_q == TMR_LAST) begin
            state_d = ST_HIGH;
            err_d   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (BYTE_ACK) begin
          state_d = ST_HIGH;
        end
      end
      default: begin
        state_d = ST_HIGH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_HIGH;
      timer_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_load_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nibble_load_ctrl : directed + random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
module tb_nibble_load_ctrl;

  localparam int TMO     = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             RESET;
  logic [3:0]       NIB_IN;
  logic             NIB_VALID;
  logic             NIB_READY;
  logic [3:0]       NIB_OUT;
  logic             EN_HIGH;
  logic             EN_LOW;
  logic             BYTE_VALID;
  logic             BYTE_ACK;
  logic             TIMEOUT_ERR;
  logic [CNT_W-1:0] BYTE_COUNT;

  int checks = 0;
  int errors = 0;

  // Reference state: what the byte assembler is conceptually doing.
  bit         m_have_high;
  bit         m_holding;
  bit         m_err;
  int         m_idle;
  int         m_count;
  logic [3:0] m_high;
  logic [7:0] m_byte;

  // Data path register driven by the controller's strobes.
  logic [7:0] dp;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (EN_HIGH) dp[7:4] <= NIB_OUT;
    if (EN_LOW)  dp[3:0] <= NIB_OUT;
  end

  nibble_load_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .CLK         (clk),
    .RESET       (RESET),
    .NIB_IN      (NIB_IN),
    .NIB_VALID   (NIB_VALID),
    .NIB_READY   (NIB_READY),
    .NIB_OUT     (NIB_OUT),
    .EN_HIGH     (EN_HIGH),
    .EN_LOW      (EN_LOW),
    .BYTE_VALID  (BYTE_VALID),
    .BYTE_ACK    (BYTE_ACK),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .BYTE_COUNT  (BYTE_COUNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit r, input bit v, input logic [3:0] n, input bit a);
    bit e_ready, e_xfer;
    RESET = r; NIB_VALID = v; NIB_IN = n; BYTE_ACK = a;
    @(negedge clk);
    e_ready = !r && !m_holding;
    e_xfer  = v && e_ready;
    chk("nib_ready",   32'(NIB_READY),   32'(e_ready));
    chk("nib_out",     32'(NIB_OUT),     32'(n));
    chk("en_high",     32'(EN_HIGH),     32'(e_xfer && !m_have_high));
    chk("en_low",      32'(EN_LOW),      32'(e_xfer && m_have_high));
    chk("byte_valid",  32'(BYTE_VALID),  32'(m_holding));
    chk("timeout_err", 32'(TIMEOUT_ERR), 32'(m_err));
    chk("byte_count",  32'(BYTE_COUNT),  32'(m_count));
    if (m_holding) chk("byte_data", 32'(dp), 32'(m_byte));
    @(posedge clk);
    #1;
    if (r) begin
      m_have_high = 0; m_holding = 0; m_err = 0; m_idle = 0; m_count = 0;
    end else if (m_holding) begin
      m_err = 0;
      if (a) m_holding = 0;
    end else if (m_have_high) begin
      if (e_xfer) begin
        m_byte      = {m_high, n};
        m_count     = (m_count + 1) % CNT_MOD;
        m_holding   = 1;
        m_have_high = 0;
        m_err       = 0;
      end else begin
        m_idle++;
        m_err = (m_idle == TMO);
        if (m_err) m_have_high = 0;
      end
    end else begin
      m_err = 0;
      if (e_xfer) begin
        m_high      = n;
        m_have_high = 1;
        m_idle      = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [3:0] hi, input logic [3:0] lo, input int ack_delay);
    step(0, 1, hi, 0);
    step(0, 1, lo, 0);
    for (int i = 0; i < ack_delay; i++) step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 1);
  endtask

  initial begin
    RESET = 1'b1; NIB_VALID = 1'b0; NIB_IN = 4'h0; BYTE_ACK = 1'b0;
    m_have_high = 0; m_holding = 0; m_err = 0; m_idle = 0; m_count = 0;
    m_high = 4'h0; m_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset with valid asserted: no strobes, reset values visible.
    step(1, 1, 4'hF, 0);

    // Single byte, immediate ack.
    send_byte(4'hA, 4'h5, 0);
    step(0, 0, 4'h0, 1);           // ack outside HOLD is ignored

    // Back-to-back bytes with delayed acks.
    send_byte(4'h1, 4'h2, 4);
    send_byte(4'h3, 4'h4, 4);
    send_byte(4'hF, 4'hF, 4);

    // Abort after the high nibble, then a fresh byte.
    step(0, 1, 4'hC, 0);
    repeat (6) step(0, 0, 4'h0, 0);
    send_byte(4'h3, 4'h9, 1);

    // Low nibble on the expiry cycle completes the byte.
    step(0, 1, 4'h6, 0);
    repeat (TMO - 1) step(0, 0, 4'h0, 0);
    step(0, 1, 4'h7, 0);
    step(0, 0, 4'h0, 1);

    // Reset while waiting for the low nibble.
    step(0, 1, 4'hE, 0);
    step(1, 1, 4'hB, 0);
    send_byte(4'h1, 4'h2, 0);

    // Counter wrap.
    for (int i = 0; i < 5; i++)
      send_byte(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

    // Random traffic, with idle stretches long enough to hit timeouts.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 6,
           4'($urandom),
           $urandom_range(0, 2) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_load_ctrl.md
# nibble_load_ctrl

Control stage directly upstream of the 8-bit nibble data path register. It accepts a 4-bit nibble stream over a valid/ready handshake and forwards each nibble to the data path. It generates the `EN_HIGH`/`EN_LOW` load strobes that assemble one byte, high nibble first. It then holds the completed byte for a downstream consumer until acknowledged, aborting a half-assembled byte if the low nibble does not arrive in time.

## Interface

- `TIMEOUT_CYCLES`, default 255: idle cycles allowed in LOW before the partial byte is abandoned; legal range ≥ 1.
- `CNT_W`, default 8: width of the completed-byte counter.

- `CLK`  in  1  system clock, all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `NIB_IN`  in  4  incoming nibble.
- `NIB_VALID`  in  1  `NIB_IN` is valid this cycle.
- `NIB_READY`  out  1  block accepts a nibble this cycle.
- `NIB_OUT`  out  4  nibble to data path `DATA_IN`.
- `EN_HIGH`  out  1  load strobe for data path bits [7:4].
- `EN_LOW`  out  1  load strobe for data path bits [3:0].
- `BYTE_VALID`  out  1  data path output holds a complete byte.
- `BYTE_ACK`  in  1  downstream has consumed the byte.
- `TIMEOUT_ERR`  out  1  one-cycle pulse when a partial byte is abandoned.
- `BYTE_COUNT`  out  `CNT_W`  completed bytes since reset, modulo 2^`CNT_W`.

## Operation

- Nibble transfer occurs on any cycle where `NIB_VALID` and `NIB_READY` are both 1.
- `NIB_OUT` is a combinational pass-through of `NIB_IN`. This lets the data path capture on the same edge as the transfer.
- FSM states: HIGH, LOW and HOLD.
- HIGH (reset state):
  - `NIB_READY`=1.
  - On transfer: `EN_HIGH`=1 combinationally; next state LOW; timer cleared to 0.
- LOW:
  - `NIB_READY`=1.
  - On transfer: `EN_LOW`=1 combinationally; next state HOLD; `BYTE_COUNT` increments, wrapping from all-ones to 0.
  - With no transfer: timer increments. If the timer equals `TIMEOUT_CYCLES`-1, next state is HIGH and `TIMEOUT_ERR` is registered to 1 for exactly one cycle.
  - A transfer in the same cycle as timer expiry takes priority: the byte completes and no error is raised.
- HOLD:
  - `NIB_READY`=0 and `BYTE_VALID`=1.
  - `BYTE_ACK`=1 moves to HIGH next cycle.
  - `BYTE_ACK` outside HOLD is ignored.
- `EN_HIGH` and `EN_LOW` are never both 1, and are 0 in HOLD.
- After a timeout the data path upper nibble keeps stale data. The next accepted nibble is treated as a new high nibble.
- Timer width is $clog2(`TIMEOUT_CYCLES`+1) bits and saturates; it never wraps.

## Timing

- Reset values: state HIGH, timer 0, `BYTE_COUNT` 0, `TIMEOUT_ERR` 0, `BYTE_VALID` 0.
- While `RESET`=1, `NIB_READY`, `EN_HIGH` and `EN_LOW` are forced to 0, whatever `NIB_VALID` is.
- Reset mid-byte, in LOW or HOLD, discards the partial or held byte. The byte counter is cleared and no `TIMEOUT_ERR` is produced.
- This block does not clear the data path register.
- Latency:
  - High-nibble transfer at edge n: data path bits [7:4] updated at edge n.
  - Low-nibble transfer at edge m: bits [3:0] updated at edge m; `BYTE_VALID`=1 from cycle m+1.
  - `BYTE_ACK` sampled at edge k: `BYTE_VALID`=0 and `NIB_READY`=1 from cycle k+1.
- Minimum byte period is 3 cycles (HIGH, LOW, HOLD with immediate ack).
- The timeout pulse occurs on the cycle after the `TIMEOUT_CYCLES`-th consecutive idle cycle in LOW.

## Structure

- Package `nibble_ctrl_pkg` holds:
  - the state enum typedef `nib_state_t` (HIGH, LOW, HOLD);
  - the nibble width constant `NIB_W`=4;
  - the byte width constant `BYTE_W`=8.
- Single module, no sub-modules. It contains the FSM register, the timer, the byte counter and the `TIMEOUT_ERR` flop.
- The top level instantiates `nibble_load_ctrl` alongside the data path:
  - `NIB_OUT`→`DATA_IN`
  - `EN_HIGH`→`en_high`
  - `EN_LOW`→`en_low`

## Test plan

- Reset then nibbles 0xA, 0x5 with `NIB_VALID` held and `BYTE_ACK` on the first HOLD cycle → data path reads 0xA5, `BYTE_VALID` high for one cycle, `BYTE_COUNT`=1, 3-cycle period.
- Back-to-back bytes 0x12, 0x34, 0xFF with `BYTE_ACK` delayed 4 cycles each → `NIB_READY`=0 throughout every HOLD; bytes 0x12, 0x34, 0xFF in order; `BYTE_COUNT`=3.
- `TIMEOUT_CYCLES`=4: send 0xC, then idle → exactly one `TIMEOUT_ERR` pulse 4 cycles later, state HIGH. Then send 0x3, 0x9 → byte 0x39; `BYTE_COUNT` unchanged by the abort.
- `TIMEOUT_CYCLES`=4: low nibble 0x7 arrives on the expiry cycle → byte completes, no `TIMEOUT_ERR`.
- `RESET` asserted in LOW after high nibble 0xE, with `NIB_VALID`=1 during the reset cycle → no `EN_*` during reset. After reset, 0x1, 0x2 yields 0x12 and `BYTE_COUNT`=1.
- `CNT_W`=2: complete 5 bytes → `BYTE_COUNT` sequence 1, 2, 3, 0, 1.
